// File: rtl/fetch_pkg.sv
// ============================================================================
// fetch_pkg
// Shared FSM states, line geometry and constants for the fetch responder.
// Revision: 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      COLLECT = 2'd2
   } fetch_state_t;

   localparam int         LINE_WORDS  = 4;
   localparam int         THREAD_ID_W = 2;
   localparam int         NUM_THREADS = 1 << THREAD_ID_W;
   localparam logic [2:0] BURST_LEN   = 3'd4;

   // Word i of a line is meaningful to the fetcher iff i >= the word offset.
   function automatic logic [LINE_WORDS-1:0] word_mask(input logic [1:0] offset);
      return 4'b1111 << offset;
   endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_line_buffer.sv
// ============================================================================
// fetch_line_buffer
// One line entry per hardware thread: combinational hit/read, single write port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_line_buffer
   import fetch_pkg::*;
#(
   parameter int TAG_WIDTH  = 20,
   parameter int DATA_WIDTH = 32
) (
   input  logic                             i_Clk,
   input  logic                             i_Reset_n,
   input  logic                             flush,
   input  logic [THREAD_ID_W-1:0]           rd_thread,
   input  logic [TAG_WIDTH-1:0]             rd_tag,
   output logic                             hit,
   output logic [LINE_WORDS*DATA_WIDTH-1:0] rd_data,
   input  logic                             wr_en,
   input  logic [THREAD_ID_W-1:0]           wr_thread,
   input  logic [TAG_WIDTH-1:0]             wr_tag,
   input  logic [LINE_WORDS*DATA_WIDTH-1:0] wr_data
);

   logic [NUM_THREADS-1:0]          valid;
   logic [TAG_WIDTH-1:0]            tags  [NUM_THREADS];
   logic [LINE_WORDS*DATA_WIDTH-1:0] lines [NUM_THREADS];

   always_ff @(posedge i_Clk or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         valid <= '0;
      end else if (flush) begin
         valid <= '0;
      end else if (wr_en) begin
         valid[wr_thread] <= 1'b1;
      end
   end

   // Payload needs no reset: it is never observed while its valid bit is low.
   always_ff @(posedge i_Clk) begin
      if (wr_en) begin
         tags[wr_thread]  <= wr_tag;
         lines[wr_thread] <= wr_data;
      end
   end

   assign hit     = valid[rd_thread] && (tags[rd_thread] == rd_tag);
   assign rd_data = lines[rd_thread];

endmodule

`default_nettype wire

// File: rtl/imem_fetch_responder.sv
// ============================================================================
// imem_fetch_responder
// Returns aligned 4-word instruction lines to the fetch unit, stalling it while
// a line is burst-read over Avalon-MM. Define FETCH_LINE_BUFFER_EN to keep a
// per-thread line buffer; otherwise every accepted request is a miss.
// Revision: 1.0
// ============================================================================
`default_nettype none

module imem_fetch_responder
   import fetch_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 22,
   parameter int DATA_WIDTH    = 32
) (
   input  logic                           i_Clk,
   input  logic                           i_Reset_n,
   input  logic                           i_Req_Valid,
   input  logic [ADDRESS_WIDTH-1:0]       i_Req_Addr,
   input  logic [THREAD_ID_W-1:0]         i_Req_Thread,
   input  logic                           i_Flush,
   output logic                           o_Stall,
   output logic                           o_Resp_Valid,
   output logic [THREAD_ID_W-1:0]         o_Resp_Thread,
   output logic [ADDRESS_WIDTH-1:0]       o_Resp_Addr,
   output logic [LINE_WORDS*DATA_WIDTH-1:0] o_Resp_Data,
   output logic [LINE_WORDS-1:0]          o_Resp_Mask,
   output logic [ADDRESS_WIDTH-1:0]       o_Mem_Address,
   output logic                           o_Mem_Read,
   output logic [2:0]                     o_Mem_BurstCount,
   input  logic                           i_Mem_WaitRequest,
   input  logic [DATA_WIDTH-1:0]          i_Mem_ReadData,
   input  logic                           i_Mem_ReadDataValid
);

   localparam int TAG_WIDTH = ADDRESS_WIDTH - 2;
   localparam int LINE_BITS = LINE_WORDS * DATA_WIDTH;

   fetch_state_t                state;
   fetch_state_t                state_next;
   logic [ADDRESS_WIDTH-1:0]    miss_addr;
   logic [THREAD_ID_W-1:0]      miss_thread;
   logic                        cancel;
   logic [1:0]                  beat_cnt;
   logic [DATA_WIDTH-1:0]       beats [LINE_WORDS-1];
   logic [LINE_BITS-1:0]        fill_data;
   logic                        last_beat;
   logic                        hit;
   logic [LINE_BITS-1:0]        hit_data;
   logic                        accept_miss;
   logic                        resp_load;
   logic [THREAD_ID_W-1:0]      resp_thread_next;
   logic [ADDRESS_WIDTH-1:0]    resp_addr_next;
   logic [LINE_BITS-1:0]        resp_data_next;

   assign last_beat = (state == COLLECT) && i_Mem_ReadDataValid && (beat_cnt == 2'd3);
   // The final beat goes straight to the response/fill path without a register stage.
   assign fill_data = {i_Mem_ReadData, beats[2], beats[1], beats[0]};

`ifdef FETCH_LINE_BUFFER_EN
   logic fill_en;
   assign fill_en = last_beat && !(cancel || i_Flush);

   fetch_line_buffer #(
      .TAG_WIDTH  (TAG_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_line_buffer (
      .i_Clk     (i_Clk),
      .i_Reset_n (i_Reset_n),
      .flush     (i_Flush),
      .rd_thread (i_Req_Thread),
      .rd_tag    (i_Req_Addr[ADDRESS_WIDTH-1:2]),
      .hit       (hit),
      .rd_data   (hit_data),
      .wr_en     (fill_en),
      .wr_thread (miss_thread),
      .wr_tag    (miss_addr[ADDRESS_WIDTH-1:2]),
      .wr_data   (fill_data)
   );
`else
   assign hit      = 1'b0;
   assign hit_data = '0;
`endif

   always_ff @(posedge i_Clk or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next       = state;
      accept_miss      = 1'b0;
      resp_load        = 1'b0;
      resp_thread_next = miss_thread;
      resp_addr_next   = miss_addr;
      resp_data_next   = fill_data;
      case (state)
         IDLE: begin
            if (i_Req_Valid && !i_Flush) begin
               if (hit) begin
                  resp_load        = 1'b1;
                  resp_thread_next = i_Req_Thread;
                  resp_addr_next   = i_Req_Addr;
                  resp_data_next   = hit_data;
               end else begin
                  accept_miss = 1'b1;
                  state_next  = REQ;
               end
            end
         end
         REQ: begin
            if (!i_Mem_WaitRequest) begin
               state_next = COLLECT;
            end
         end
         COLLECT: begin
            if (last_beat) begin
               state_next = IDLE;
               resp_load  = !(cancel || i_Flush);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_Clk or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         miss_addr     <= '0;
         miss_thread   <= '0;
         cancel        <= 1'b0;
         beat_cnt      <= '0;
         for (int i = 0; i < LINE_WORDS - 1; i++) begin
            beats[i] <= '0;
         end
         o_Resp_Valid  <= 1'b0;
         o_Resp_Thread <= '0;
         o_Resp_Addr   <= '0;
         o_Resp_Data   <= '0;
         o_Resp_Mask   <= '0;
      end else begin
         o_Resp_Valid <= resp_load;
         if (resp_load) begin
            o_Resp_Thread <= resp_thread_next;
            o_Resp_Addr   <= resp_addr_next;
            o_Resp_Data   <= resp_data_next;
            o_Resp_Mask   <= word_mask(resp_addr_next[1:0]);
         end

         // A flush cannot withdraw an issued burst, so the miss is drained and dropped.
         if (accept_miss) begin
            miss_addr   <= i_Req_Addr;
            miss_thread <= i_Req_Thread;
            cancel      <= 1'b0;
         end else if (i_Flush && (state != IDLE)) begin
            cancel <= 1'b1;
         end

         if ((state == COLLECT) && i_Mem_ReadDataValid) begin
            beat_cnt <= beat_cnt + 2'd1;
            case (beat_cnt)
               2'd0:    beats[0] <= i_Mem_ReadData;
               2'd1:    beats[1] <= i_Mem_ReadData;
               2'd2:    beats[2] <= i_Mem_ReadData;
               default: ;
            endcase
         end
      end
   end

   assign o_Stall          = (state != IDLE);
   assign o_Mem_Read       = (state == REQ);
   assign o_Mem_Address    = {miss_addr[ADDRESS_WIDTH-1:2], 2'b00};
   assign o_Mem_BurstCount = BURST_LEN;

endmodule

`default_nettype wire

// File: tb/tb_imem_fetch_responder.sv
// ============================================================================
// tb_imem_fetch_responder
// Directed bench with a transaction-level reference model and per-cycle compare.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_imem_fetch_responder;

   localparam int AW = 22;
   localparam int DW = 32;
`ifdef FETCH_LINE_BUFFER_EN
   localparam bit LB = 1'b1;
`else
   localparam bit LB = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_valid;
   logic [AW-1:0] req_addr;
   logic [1:0]    req_thread;
   logic          flush;
   logic          stall;
   logic          resp_valid;
   logic [1:0]    resp_thread;
   logic [AW-1:0] resp_addr;
   logic [127:0]  resp_data;
   logic [3:0]    resp_mask;
   logic [AW-1:0] mem_address;
   logic          mem_read;
   logic [2:0]    mem_burst;
   logic          mem_wait;
   logic [DW-1:0] mem_rdata;
   logic          mem_rdv;

   imem_fetch_responder #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .i_Clk               (clk),
      .i_Reset_n           (rst_n),
      .i_Req_Valid         (req_valid),
      .i_Req_Addr          (req_addr),
      .i_Req_Thread        (req_thread),
      .i_Flush             (flush),
      .o_Stall             (stall),
      .o_Resp_Valid        (resp_valid),
      .o_Resp_Thread       (resp_thread),
      .o_Resp_Addr         (resp_addr),
      .o_Resp_Data         (resp_data),
      .o_Resp_Mask         (resp_mask),
      .o_Mem_Address       (mem_address),
      .o_Mem_Read          (mem_read),
      .o_Mem_BurstCount    (mem_burst),
      .i_Mem_WaitRequest   (mem_wait),
      .i_Mem_ReadData      (mem_rdata),
      .i_Mem_ReadDataValid (mem_rdv)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Memory content: each word carries its own address, tagged in the top bits.
   function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
      return {10'h2A5, a};
   endfunction

   function automatic logic [127:0] line_of(input logic [AW-1:0] a);
      logic [127:0] d;
      logic [AW-1:0] base;
      base = {a[AW-1:2], 2'b00};
      for (int i = 0; i < 4; i++) d[i*32 +: 32] = mem_word(base + AW'(i));
      return d;
   endfunction

   typedef struct {
      int            cyc;
      logic [1:0]    t;
      logic [AW-1:0] a;
      logic [127:0]  d;
      logic [3:0]    m;
   } resp_t;

   resp_t         rq[$];
   int            st_lo = 1, st_hi = 0;
   int            rd_lo = 1, rd_hi = 0;
   logic [AW-1:0] rd_addr_exp = '0;
   logic [AW-1:0] last_rd_addr = '0;
   int            gap_n = 0;
   bit            chk_en = 1'b0;
`ifdef FETCH_LINE_BUFFER_EN
   bit            m_valid [4];
   logic [AW-3:0] m_tag   [4];
`endif

   task automatic model_clear();
`ifdef FETCH_LINE_BUFFER_EN
      for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
`endif
   endtask

   // Avalon slave: command accepted on a cycle with read high and waitrequest low.
   initial begin
      logic [AW-1:0] base;
      mem_rdv   = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (rst_n && mem_read && !mem_wait) begin
            base = mem_address;
            for (int b = 0; b < 4; b++) begin
               if (b == 2) begin
                  for (int k = 0; k < gap_n; k++) begin
                     @(posedge clk); #2;
                     mem_rdv = 1'b0;
                  end
               end
               @(posedge clk); #2;
               if (!rst_n) begin
                  mem_rdv = 1'b0;
                  break;
               end
               mem_rdv   = 1'b1;
               mem_rdata = mem_word(base + AW'(b));
            end
            @(posedge clk); #2;
            mem_rdv = 1'b0;
         end
      end
   end

   initial begin
      bit ev;
      forever begin
         @(negedge clk);
         if (chk_en) begin
            chk("stall", stall, (cyc >= st_lo && cyc <= st_hi));
            ev = (cyc >= rd_lo && cyc <= rd_hi);
            chk("mem_read", mem_read, ev);
            if (ev) begin
               chk("mem_addr", mem_address, rd_addr_exp);
               chk("burst", mem_burst, 3'd4);
               last_rd_addr = mem_address;
            end
            ev = (rq.size() > 0) && (rq[0].cyc == cyc);
            chk("resp_valid", resp_valid, ev);
            if (ev) begin
               chk("resp_thread", resp_thread, rq[0].t);
               chk("resp_addr", resp_addr, rq[0].a);
               chk("resp_data", resp_data, rq[0].d);
               chk("resp_mask", resp_mask, rq[0].m);
               void'(rq.pop_front());
            end
         end
      end
   end

   // Called in cycle c (just after its opening edge); returns in the cycle after
   // the transaction ends, where the next request may be presented.
   task automatic issue(input logic [AW-1:0] a, input logic [1:0] t, input int w,
                        input int g, input int fl_off, output bit hit);
      int    c;
      resp_t r;
      c   = cyc;
      hit = 1'b0;
`ifdef FETCH_LINE_BUFFER_EN
      hit = m_valid[t] && (m_tag[t] == a[AW-1:2]);
`endif
      r.t = t;
      r.a = a;
      r.d = line_of(a);
      for (int i = 0; i < 4; i++) r.m[i] = (i >= int'(a[1:0]));
      if (hit) begin
         r.cyc = c + 1;
         rq.push_back(r);
      end else begin
         st_lo       = c + 1;
         st_hi       = c + 5 + w + g;
         rd_lo       = c + 1;
         rd_hi       = c + 1 + w;
         rd_addr_exp = {a[AW-1:2], 2'b00};
         gap_n       = g;
         if (fl_off < 0) begin
            r.cyc = c + 6 + w + g;
            rq.push_back(r);
`ifdef FETCH_LINE_BUFFER_EN
            m_valid[t] = 1'b1;
            m_tag[t]   = a[AW-1:2];
`endif
         end else begin
            model_clear();
         end
      end
      req_valid  = 1'b1;
      req_addr   = a;
      req_thread = t;
      @(posedge clk); #1;
      req_valid = 1'b0;
      if (!hit) begin
         while (cyc < c + 6 + w + g) begin
            mem_wait = (cyc <= c + w);
            flush    = (cyc == c + fl_off);
            @(posedge clk); #1;
         end
         mem_wait = 1'b0;
         flush    = 1'b0;
      end
   endtask

   task automatic miss_then_reset(input logic [AW-1:0] a, input logic [1:0] t);
      int c;
      c           = cyc;
      st_lo       = c + 1;
      st_hi       = c + 2;
      rd_lo       = c + 1;
      rd_hi       = c + 1;
      rd_addr_exp = {a[AW-1:2], 2'b00};
      gap_n       = 0;
      req_valid   = 1'b1;
      req_addr    = a;
      req_thread  = t;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("rst_async_stall", stall, 1'b0);
      chk("rst_async_resp_valid", resp_valid, 1'b0);
      chk("rst_async_mem_read", mem_read, 1'b0);
      chk("rst_async_mem_addr", mem_address, '0);
      chk("rst_async_resp_addr", resp_addr, '0);
      chk("rst_async_resp_data", resp_data, '0);
      chk("rst_async_resp_mask", resp_mask, '0);
      model_clear();
      repeat (2) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b1;
   endtask

   initial begin
      bit h;
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_addr   = '0;
      req_thread = '0;
      flush      = 1'b0;
      mem_wait   = 1'b0;
      model_clear();
      repeat (3) @(posedge clk);
      #1;
      chk("reset_stall", stall, 1'b0);
      chk("reset_resp_valid", resp_valid, 1'b0);
      chk("reset_mem_read", mem_read, 1'b0);
      chk("reset_mem_addr", mem_address, '0);
      chk("reset_resp_data", resp_data, '0);
      chk("reset_resp_mask", resp_mask, '0);
      rst_n  = 1'b1;
      chk_en = 1'b1;
      @(posedge clk); #1;

      issue(22'h10, 2'd0, 0, 0, -1, h);
      chk("t1_is_miss", h, 1'b0);
      chk("t1_resp_valid", resp_valid, 1'b1);
      chk("t1_stall_low", stall, 1'b0);
      chk("t1_mask", resp_mask, 4'b1111);
      chk("t1_word0", resp_data[31:0], 32'hA940_0010);
      chk("t1_word3", resp_data[127:96], 32'hA940_0013);
      chk("t1_mem_addr", last_rd_addr, 22'h10);

      issue(22'h12, 2'd0, 0, 0, -1, h);
      chk("t2_hit", h, LB);
      chk("t2_resp_valid", resp_valid, 1'b1);
      chk("t2_mask", resp_mask, 4'b1100);
      chk("t2_addr", resp_addr, 22'h12);

      issue(22'h12, 2'd1, 0, 0, -1, h);
      chk("t3_other_thread_miss", h, 1'b0);
      chk("t3_thread", resp_thread, 2'd1);

      issue(22'h20, 2'd2, 3, 0, -1, h);
      chk("t4_wait_resp_valid", resp_valid, 1'b1);
      chk("t4_word0", resp_data[31:0], 32'hA940_0020);

      issue(22'h33, 2'd3, 0, 2, -1, h);
      chk("t5_gap_mask", resp_mask, 4'b1000);
      chk("t5_word2", resp_data[95:64], 32'hA940_0032);

      issue(22'h24, 2'd0, 0, 0, 4, h);
      chk("t6_flush_collect_no_resp", resp_valid, 1'b0);
      chk("t6_flush_collect_stall", stall, 1'b0);

      issue(22'h10, 2'd0, 0, 0, -1, h);
      chk("t7_after_flush_miss", h, 1'b0);
      chk("t7_resp_valid", resp_valid, 1'b1);

      issue(22'h40, 2'd1, 2, 0, 1, h);
      chk("t8_flush_req_no_resp", resp_valid, 1'b0);
      chk("t8_flush_req_stall", stall, 1'b0);

      miss_then_reset(22'h50, 2'd0);
      @(posedge clk); #1;

      issue(22'h10, 2'd0, 0, 0, -1, h);
      chk("t9_after_reset_miss", h, 1'b0);
      chk("t9_word1", resp_data[63:32], 32'hA940_0011);

      issue(22'h11, 2'd0, 0, 0, -1, h);
      chk("t10_hit", h, LB);
      chk("t10_mask", resp_mask, 4'b1110);

      repeat (3) @(posedge clk);
      #1;
      chk("resp_queue_drained", rq.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/imem_fetch_responder.md
# imem_fetch_responder

Responder end of the instruction-fetch request path: accepts the per-thread word address issued by the fetch unit, returns the aligned 4-word instruction line containing it, and drives the stall that holds the fetch unit while a line is brought in from instruction memory. Sits between the fetch unit (request side) and an Avalon-MM burst-read memory port (memory side). Keeps one line buffer entry per hardware thread so sequential fetches within a line hit without a memory access.

## Interface
Parameters:
- ADDRESS_WIDTH, 22, word address width; line address = addr[ADDRESS_WIDTH-1:2]
- DATA_WIDTH, 32, instruction word width

Ports:
- i_Clk  in  1  clock
- i_Reset_n  in  1  reset: i_Reset_n, asynchronous, active-low; clock i_Clk
- i_Req_Valid  in  1  fetch request present
- i_Req_Addr  in  ADDRESS_WIDTH  requested PC (word address)
- i_Req_Thread  in  2  requesting thread id
- i_Flush  in  1  invalidate all line buffer entries, cancel outstanding miss
- o_Stall  out  1  high while a miss is outstanding; wired to fetch unit i_Stall
- o_Resp_Valid  out  1  one-cycle response pulse
- o_Resp_Thread  out  2  thread id of response
- o_Resp_Addr  out  ADDRESS_WIDTH  request address echoed
- o_Resp_Data  out  4*DATA_WIDTH  line words, word 0 in bits [DATA_WIDTH-1:0]
- o_Resp_Mask  out  4  bit i set iff i >= addr[1:0]
- o_Mem_Address  out  ADDRESS_WIDTH  line base (addr[1:0]=0)
- o_Mem_Read  out  1  burst read request
- o_Mem_BurstCount  out  3  constant 4
- i_Mem_WaitRequest  in  1  memory not accepting
- i_Mem_ReadData  in  DATA_WIDTH  read beat
- i_Mem_ReadDataValid  in  1  beat valid

## Operation
- Accept: rising edge with i_Req_Valid=1, o_Stall=0, i_Flush=0. Otherwise request ignored.
- Lookup (combinational at accept): hit iff entry[i_Req_Thread] valid and tag == i_Req_Addr[ADDRESS_WIDTH-1:2].
- Hit: response registered, state stays IDLE.
- Miss: latch addr/thread, state IDLE->REQ.
- States: IDLE; REQ (o_Mem_Read=1, o_Mem_Address held until i_Mem_WaitRequest=0, then ->COLLECT); COLLECT (2-bit beat counter, beats stored in order; on 4th beat -> IDLE, fill entry[thread], pulse response).
- o_Stall = (state != IDLE), registered.
- i_Flush: clears all valid bits same edge. In REQ: command still issued (Avalon rule: no withdrawal), then beats drained. In REQ/COLLECT: cancel flag set; on completion no fill, no response.
- i_Mem_ReadDataValid in IDLE/REQ ignored.
- Reset: state IDLE, all valid bits 0, beat counter 0, o_Stall 0, o_Resp_Valid 0, o_Resp_* 0, o_Mem_Read 0, o_Mem_Address 0. Memory port must be reset together (no stale beats after reset).

## Timing
- Hit: accept at edge T, o_Resp_Valid high in cycle T+1 only.
- Miss (zero waitrequest, back-to-back beats): accept T0; o_Stall and o_Mem_Read high cycle 1; beats cycles 2-5; o_Resp_Valid and o_Stall=0 in cycle 6. Each waitrequest or gap cycle adds one.
- Next request acceptable at the edge ending the response cycle.

## Configuration
- FETCH_LINE_BUFFER_EN defined: per-thread line buffer as above.
- Undefined: no storage, every accept is a miss; flush only cancels outstanding miss.

## Structure
- Package fetch_pkg: state enum (IDLE, REQ, COLLECT), LINE_WORDS=4, THREAD_ID_W=2, BURST_LEN constant.
- Sub-module fetch_line_buffer: 4 entries of valid/tag/4 words, combinational hit/read, write port, flush; omitted when macro undefined.

## Test plan
- Reset, request addr 0x10 thread 0 -> o_Stall 1 cycle 1, o_Mem_Address 0x10, burst 4; response cycle 6, mask 4'b1111.
- Follow with addr 0x12 thread 0 -> hit, response next cycle, mask 4'b1100, no o_Mem_Read.
- Thread 1 addr 0x12 after thread 0 fill -> miss (per-thread entries).
- i_Mem_WaitRequest high 3 cycles during REQ -> address held, response delayed 3 cycles.
- i_Flush in COLLECT after beat 2 -> beats drained, no response, o_Stall drops; re-request 0x10 -> miss.
- Reset asserted mid-COLLECT -> all outputs 0 immediately; next 0x10 -> miss.
